// File: rtl/arduino_uart_pkg.sv
// Shared types and command codes for the Arduino serial link and mode_select.
package arduino_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [7:0] CMD_MANUAL = 8'h00;
    localparam logic [7:0] CMD_AUTO   = 8'hFF;

    // Sample point in the middle of the start bit, counted from its detection.
    function automatic int half_bit_count(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous Arduino pins; the reset value matches
// the pin's idle level so no false edge appears on reset release.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/arduino_uart_rx.sv
// 8N1 receiver for the Arduino command link; holds the last good byte for mode_select.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | counting to the start-bit midpoint to reject glitches
// DATA  | sampling 8 data bits LSB first at bit midpoints
// STOP  | counting to the stop-bit midpoint, then commit or flag error
// BREAK | stop bit was low; wait for the line to return high
module arduino_uart_rx
    import arduino_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] arduino_command,
    output logic       cmd_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(half_bit_count(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_baud_check
            $error("arduino_uart_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             stop_sample;
    logic             cmd_load;
    logic             ferr_nxt;
    logic             busy_nxt;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (cnt == HALF) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (cnt == LAST && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (cnt == LAST) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Returning to IDLE at the stop midpoint leaves half a bit to catch the next start.
    always_comb begin
        stop_sample = (state == STOP) && (cnt == LAST);
        cmd_load    = stop_sample && rx_s;
        ferr_nxt    = stop_sample && !rx_s;
        busy_nxt    = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        shift_reg[bit_idx] <= rx_s;
                        bit_idx            <= bit_idx + 3'd1;
                        cnt                <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arduino_command <= CMD_MANUAL;
            cmd_valid       <= 1'b0;
            frame_error     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            cmd_valid   <= cmd_load;
            frame_error <= ferr_nxt;
            busy        <= busy_nxt;
            if (cmd_load) begin
                arduino_command <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_arduino_uart_rx.sv
// Directed bench for arduino_uart_rx at 10 clocks per bit.
module tb_arduino_uart_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] arduino_command;
    logic       cmd_valid;
    logic       frame_error;
    logic       busy;

    arduino_uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uart_rx         (uart_rx),
        .arduino_command (arduino_command),
        .cmd_valid       (cmd_valid),
        .frame_error     (frame_error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int         valid_cyc[$];
    logic [7:0] valid_vals[$];

    always @(negedge clk) begin
        cyc++;
        if (cmd_valid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            valid_vals.push_back(arduino_command);
        end
        if (frame_error) ferr_cnt++;
        if (cmd_valid && frame_error) both_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold_line(input logic level, input int clocks);
        uart_rx = level;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        hold_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_line(data[i], CPB);
        hold_line(stop_bit, CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         extra_low;
        logic [7:0] exp_cmd;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, waited;
        logic seen;
        logic [7:0] cmd0;
        logic [7:0] partial;

        vecs[0] = '{8'hFF, 1'b1, 0,  8'hFF, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 0,  8'h00, 1, 0};
        vecs[2] = '{8'hA5, 1'b1, 0,  8'hA5, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 0,  8'hFF, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 20, 8'hFF, 0, 1};
        vecs[5] = '{8'h12, 1'b1, 0,  8'h12, 1, 0};

        // reset
        repeat (3) @(negedge clk);
        check("reset_cmd", int'(arduino_command), 8'h00);
        check("reset_flags", int'({cmd_valid, frame_error, busy}), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_after_reset", int'({arduino_command, cmd_valid, frame_error, busy}), 0);
        end

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            if (vecs[i].extra_low > 0) begin
                hold_line(1'b0, vecs[i].extra_low);
                check("busy_in_break", int'(busy), 1);
                uart_rx = 1'b1;
                waited = 0;
                while (busy && waited < 10) begin
                    @(negedge clk);
                    waited++;
                end
                check("break_exit", int'(busy), 0);
            end
            hold_line(1'b1, 2 * CPB);
            check($sformatf("vec%0d_cmd", i), int'(arduino_command), int'(vecs[i].exp_cmd));
            check($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_busy_idle", i), int'(busy), 0);
        end

        // glitch shorter than half a bit
        v0 = valid_cnt;
        f0 = ferr_cnt;
        cmd0 = arduino_command;
        seen = 1'b0;
        uart_rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        uart_rx = 1'b1;
        waited = 0;
        while ((busy || !seen) && waited < 7) begin
            @(negedge clk);
            waited++;
            if (busy) seen = 1'b1;
        end
        check("glitch_busy_seen", int'(seen), 1);
        check("glitch_busy_drop", int'(busy), 0);
        hold_line(1'b1, 2 * CPB);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_cmd", int'(arduino_command), int'(cmd0));

        // reset during data bit 4 of 0x55
        v0 = valid_cnt;
        partial = 8'h55;
        hold_line(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold_line(partial[i], CPB);
        hold_line(partial[4], CPB / 2);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_cmd", int'(arduino_command), 8'h00);
        check("midreset_flags", int'({cmd_valid, frame_error, busy}), 0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold_line(1'b1, 2 * CPB);
        check("midreset_no_valid", valid_cnt - v0, 0);
        check("midreset_cmd_held", int'(arduino_command), 8'h00);
        send_frame(8'h0F, 1'b1);
        hold_line(1'b1, 2 * CPB);
        check("after_reset_cmd", int'(arduino_command), 8'h0F);
        check("after_reset_valid", valid_cnt - v0, 1);

        // back-to-back frames, no idle gap
        valid_cyc.delete();
        valid_vals.delete();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        hold_line(1'b1, 2 * CPB);
        check("b2b_pulses", valid_cyc.size(), 2);
        if (valid_cyc.size() == 2) begin
            check("b2b_first", int'(valid_vals[0]), 8'h01);
            check("b2b_second", int'(valid_vals[1]), 8'h02);
            check("b2b_spacing", valid_cyc[1] - valid_cyc[0], 10 * CPB);
        end
        check("b2b_cmd", int'(arduino_command), 8'h02);

        check("valid_ferr_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
